// File: rtl/systolic_result_writeback.sv
// Result writeback stage for the systolic array: snapshots a finished tile on start
// and streams it to memory one row per beat, honouring waitrequest and edge-tile clipping.
module systolic_result_writeback #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BANDWIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [N*N*DATA_WIDTH-1:0]       tile,
    input  logic [ADDR_WIDTH-1:0]           base_C,
    input  logic [DIM_WIDTH-1:0]            dim_col_C,
    input  logic [3:0]                      valid_rows,
    input  logic [3:0]                      valid_cols,
    input  logic                            waitrequest,
    output logic                            write,
    output logic [ADDR_WIDTH-1:0]           write_addr,
    output logic [BANDWIDTH*DATA_WIDTH-1:0] writedata,
    output logic [BANDWIDTH-1:0]            word_en,
    output logic                            busy,
    output logic                            done
);

    localparam int         RIDX  = (N > 1) ? $clog2(N) : 1;
    localparam int         ROW_W = N * DATA_WIDTH;
    localparam logic [3:0] N4    = 4'(N);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [N*N*DATA_WIDTH-1:0] buffer;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DIM_WIDTH-1:0]    stride;
    logic [3:0]              rows;
    logic [3:0]              cols;
    logic [RIDX-1:0]         r;
    logic [3:0]              rows_clamped;
    logic [3:0]              cols_clamped;
    logic                    accept;
    logic                    last_row;
    logic [ROW_W-1:0]        cur_row;

    assign rows_clamped = (valid_rows > N4) ? N4 : valid_rows;
    assign cols_clamped = (valid_cols > N4) ? N4 : valid_cols;
    assign accept       = (state == WRITE) && !waitrequest;
    assign last_row     = (4'(r) == (rows - 4'd1));
    assign cur_row      = buffer[int'(r)*ROW_W +: ROW_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (rows_clamped == 4'd0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept && last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The row address is accumulated one stride per accepted beat so no multiplier is needed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer <= '0;
            addr   <= '0;
            stride <= '0;
            rows   <= '0;
            cols   <= '0;
            r      <= '0;
        end else if (state == IDLE && start) begin
            buffer <= tile;
            addr   <= base_C;
            stride <= dim_col_C;
            rows   <= rows_clamped;
            cols   <= cols_clamped;
            r      <= '0;
        end else if (accept && !last_row) begin
            r    <= r + RIDX'(1);
            addr <= addr + ADDR_WIDTH'(stride);
        end
    end

    assign write      = (state == WRITE);
    assign busy       = (state == WRITE);
    assign done       = (state == DONE);
    assign write_addr = write ? addr : '0;

    // Words beyond the tile width are tied off so wide ports never write stale lanes.
    for (genvar m = 0; m < BANDWIDTH; m++) begin : g_word
        if (m < N) begin : g_live
            assign writedata[m*DATA_WIDTH +: DATA_WIDTH] =
                write ? cur_row[m*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign word_en[m] = write && (cols > 4'(m));
        end else begin : g_pad
            assign writedata[m*DATA_WIDTH +: DATA_WIDTH] = '0;
            assign word_en[m] = 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_result_writeback.sv
// Scoreboard bench for systolic_result_writeback: expected beats are queued at start
// and matched against accepted beats, with stall-hold, done timing and abort checks.
module tb_systolic_result_writeback;

    localparam int N          = 8;
    localparam int DATA_WIDTH = 32;
    localparam int BANDWIDTH  = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DIM_WIDTH  = 16;
    localparam int TW         = BANDWIDTH * DATA_WIDTH;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [TW-1:0]         data;
        logic [BANDWIDTH-1:0]  en;
        int                    cyc;
    } beat_t;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      start;
    logic [N*N*DATA_WIDTH-1:0] tile;
    logic [ADDR_WIDTH-1:0]     base_C;
    logic [DIM_WIDTH-1:0]      dim_col_C;
    logic [3:0]                valid_rows;
    logic [3:0]                valid_cols;
    logic                      waitrequest;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     write_addr;
    logic [TW-1:0]             writedata;
    logic [BANDWIDTH-1:0]      word_en;
    logic                      busy;
    logic                      done;

    beat_t exp_q[$];
    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    cyc          = 0;
    int    c0           = 0;
    int    accepted     = 0;
    int    done_count   = 0;
    int    done_cycle   = -1;

    logic                  prev_stall = 1'b0;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [TW-1:0]         held_data;
    logic [BANDWIDTH-1:0]  held_en;

    systolic_result_writeback #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .BANDWIDTH(BANDWIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .tile(tile),
        .base_C(base_C), .dim_col_C(dim_col_C), .valid_rows(valid_rows),
        .valid_cols(valid_cols), .waitrequest(waitrequest), .write(write),
        .write_addr(write_addr), .writedata(writedata), .word_en(word_en),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [TW-1:0] actual,
                               input logic [TW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] toFloat(input int v);
        int          e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    task automatic buildTile(input int seed, output logic [N*N*DATA_WIDTH-1:0] t);
        t = '0;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++)
                t[(rr*N+cc)*DATA_WIDTH +: DATA_WIDTH] = toFloat(seed + rr*N + cc);
    endtask

    // Stalled beats must repeat the previous sample exactly; accepted beats pop the scoreboard.
    always @(negedge clock) begin
        beat_t b;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_write", write, 1'b1);
                checkOutput("hold_addr", write_addr, held_addr);
                checkOutput("hold_data", writedata, held_data);
                checkOutput("hold_en", word_en, held_en);
            end
            if (write) begin
                checkOutput("busy_in_write", busy, 1'b1);
                if (!waitrequest) begin
                    checkOutput("beat_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        checkOutput("beat_addr", write_addr, b.addr);
                        checkOutput("beat_data", writedata, b.data);
                        checkOutput("beat_en", word_en, b.en);
                        checkOutput("beat_cycle", cyc - c0, b.cyc);
                    end
                    accepted++;
                end
            end
            if (done) begin
                done_count++;
                done_cycle = cyc - c0;
                checkOutput("busy_at_done", busy, 1'b0);
            end
            prev_stall = write && waitrequest;
            held_addr  = write_addr;
            held_data  = writedata;
            held_en    = word_en;
        end
    end

    task automatic applyStimulus(input int seed, input logic [ADDR_WIDTH-1:0] base,
                                 input logic [DIM_WIDTH-1:0] dim, input logic [3:0] rows,
                                 input logic [3:0] cols, input logic [31:0] stall_mask,
                                 input int poke_cycle, input int abort_after);
        logic [N*N*DATA_WIDTH-1:0] t;
        logic [N*N*DATA_WIDTH-1:0] t2;
        beat_t b;
        int    rc, cc, tt, exp_done;
        bit    aborted;
        buildTile(seed, t);
        rc = (rows > 8) ? 8 : int'(rows);
        cc = (cols > 8) ? 8 : int'(cols);
        tt = 1;
        for (int rr = 0; rr < rc; rr++) begin
            while (stall_mask[tt]) tt++;
            b.addr = base + 32'(rr) * 32'(dim);
            b.data = '0;
            for (int k = 0; k < N; k++)
                b.data[k*DATA_WIDTH +: DATA_WIDTH] = t[(rr*N+k)*DATA_WIDTH +: DATA_WIDTH];
            b.en  = 8'((1 << cc) - 1);
            b.cyc = tt;
            exp_q.push_back(b);
            tt++;
        end
        exp_done = tt;
        aborted  = 1'b0;

        @(posedge clock); #1;
        accepted   = 0;
        done_count = 0;
        done_cycle = -1;
        tile       = t;
        base_C     = base;
        dim_col_C  = dim;
        valid_rows = rows;
        valid_cols = cols;
        waitrequest = 1'b0;
        start      = 1'b1;
        c0         = cyc;

        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            start       = 1'b0;
            waitrequest = (k < 32) ? stall_mask[k] : 1'b0;
            if (abort_after > 0 && accepted == abort_after) begin
                checkOutput("pre_abort_write", write, 1'b1);
                reset = 1'b1;
                #1;
                checkOutput("abort_write", write, 1'b0);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_done", done, 1'b0);
                checkOutput("abort_addr", write_addr, '0);
                checkOutput("abort_en", word_en, '0);
                aborted = 1'b1;
                break;
            end
            if (k == poke_cycle) begin
                buildTile(seed + 1000, t2);
                tile  = t2;
                start = 1'b1;
            end
            @(negedge clock); #1;
            if (done_count > 0) break;
        end
        waitrequest = 1'b0;
        start       = 1'b0;

        if (aborted) begin
            @(posedge clock); #1;
            reset = 1'b0;
            exp_q.delete();
            @(negedge clock); #1;
            checkOutput("abort_no_done", done_count, 0);
            checkOutput("post_abort_idle", {write, busy, done}, 3'b000);
        end else begin
            checkOutput("done_count", done_count, 1);
            checkOutput("done_cycle", done_cycle, exp_done);
            checkOutput("beats_accepted", accepted, rc);
            checkOutput("beats_left", exp_q.size(), 0);
            repeat (2) @(posedge clock);
            @(negedge clock); #1;
            checkOutput("idle_after", {write, busy}, 2'b00);
            checkOutput("single_done", done_count, 1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        tile        = '0;
        base_C      = '0;
        dim_col_C   = '0;
        valid_rows  = '0;
        valid_cols  = '0;
        waitrequest = 1'b0;
        @(posedge clock); #1;
        checkOutput("reset_write", write, 1'b0);
        checkOutput("reset_addr", write_addr, '0);
        checkOutput("reset_data", writedata, '0);
        checkOutput("reset_en", word_en, '0);
        checkOutput("reset_busy_done", {busy, done}, 2'b00);
        reset = 1'b0;

        $display("[TB] full tile");
        applyStimulus(0, 32'h100, 16'd16, 4'd8, 4'd8, 32'h0, 0, 0);
        $display("[TB] backpressure");
        applyStimulus(0, 32'h100, 16'd16, 4'd8, 4'd8, 32'h26, 0, 0);
        $display("[TB] edge tile");
        applyStimulus(5, 32'h40, 16'd20, 4'd3, 4'd5, 32'h0, 0, 0);
        $display("[TB] clamped rows and cols");
        applyStimulus(9, 32'h1000, 16'd8, 4'd12, 4'd12, 32'h0, 0, 0);
        $display("[TB] zero rows");
        applyStimulus(3, 32'h80, 16'd8, 4'd0, 4'd8, 32'h0, 0, 0);
        $display("[TB] address wrap with no columns enabled");
        applyStimulus(7, 32'hFFFF_FFF8, 16'h10, 4'd2, 4'd0, 32'h4, 0, 0);
        $display("[TB] zero stride");
        applyStimulus(11, 32'h300, 16'd0, 4'd4, 4'd7, 32'h0, 0, 0);
        $display("[TB] snapshot with ignored start");
        applyStimulus(20, 32'h500, 16'd32, 4'd6, 4'd8, 32'h0, 3, 0);
        $display("[TB] reset mid-transfer");
        applyStimulus(30, 32'h700, 16'd16, 4'd8, 4'd8, 32'h0, 0, 3);
        applyStimulus(40, 32'h200, 16'd16, 4'd8, 4'd8, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
